// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: address map,
// STATUS bit positions, access classification and register selects.
package dmem_pkg;

    localparam logic [31:0] GPIO_OUT_ADDR = 32'h0000_1000;
    localparam logic [31:0] GPIO_IN_ADDR  = 32'h0000_1004;
    localparam logic [31:0] CYCLE_ADDR    = 32'h0000_1008;
    localparam logic [31:0] STATUS_ADDR   = 32'h0000_100C;

    localparam int ST_MISALIGNED = 0;
    localparam int ST_UNMAPPED   = 1;
    localparam int ST_COLLISION  = 2;
    localparam int ST_W          = 3;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_RAM,
        ACC_REG,
        ACC_UNMAPPED,
        ACC_MISALIGNED
    } acc_t;

    typedef enum logic [1:0] {
        REG_GPIO_OUT,
        REG_GPIO_IN,
        REG_CYCLE,
        REG_STATUS
    } reg_sel_t;

endpackage

// File: rtl/dmem_decode.sv
// Combinational address decoder for the data-memory responder.
// Ports: daddr, MemRead, MemWrite in; acc (access class), word_idx
// (RAM word index daddr[11:2]), reg_sel (register select) out.
// Macro DMEM_CYCLE_COUNTER_EN maps the CYCLE register; otherwise
// its address decodes as unmapped.
module dmem_decode
    import dmem_pkg::*;
#(
    parameter int DATA_SIZE = 1024,
    parameter int ADDR_SIZE = 32
) (
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    output acc_t                 acc,
    output logic [9:0]           word_idx,
    output reg_sel_t             reg_sel
);

    logic in_ram;
    logic is_reg;

    always_comb begin
        word_idx = daddr[11:2];
        // Words beyond DATA_SIZE have no backing storage.
        in_ram = (daddr[ADDR_SIZE-1:12] == '0)
              && (int'(daddr[11:2]) < DATA_SIZE);

        is_reg  = 1'b1;
        reg_sel = REG_GPIO_OUT;
        case (daddr)
            ADDR_SIZE'(GPIO_OUT_ADDR): reg_sel = REG_GPIO_OUT;
            ADDR_SIZE'(GPIO_IN_ADDR):  reg_sel = REG_GPIO_IN;
`ifdef DMEM_CYCLE_COUNTER_EN
            ADDR_SIZE'(CYCLE_ADDR):    reg_sel = REG_CYCLE;
`endif
            ADDR_SIZE'(STATUS_ADDR):   reg_sel = REG_STATUS;
            default:                   is_reg  = 1'b0;
        endcase

        // Alignment is judged before the map, so a misaligned hit
        // anywhere reports as misaligned rather than unmapped.
        if (!(MemRead || MemWrite)) begin
            acc = ACC_NONE;
        end else if (daddr[1:0] != 2'b00) begin
            acc = ACC_MISALIGNED;
        end else if (in_ram) begin
            acc = ACC_RAM;
        end else if (is_reg) begin
            acc = ACC_REG;
        end else begin
            acc = ACC_UNMAPPED;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle data-bus responder: RAM plus GPIO/CYCLE/STATUS registers.
// Ports: CLK, RESET (sync, active-high), MemRead, MemWrite, daddr,
// ddata_w in; ddata_r (combinational load data) out; gpio_in (async) in;
// gpio_out, err (registered) out.
// Macro DMEM_CYCLE_COUNTER_EN adds the free-running 32-bit CYCLE counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_SIZE = 1024,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic [ADDR_SIZE-1:0] ddata_w,
    output logic [ADDR_SIZE-1:0] ddata_r,
    input  logic [15:0]          gpio_in,
    output logic [15:0]          gpio_out,
    output logic                 err
);

    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    acc_t             acc;
    reg_sel_t         reg_sel;
    logic [9:0]       word_idx;
    logic [IDX_W-1:0] ram_idx;

    logic [ADDR_SIZE-1:0] ram [DATA_SIZE];

    logic [15:0]     sync1;
    logic [15:0]     sync2;
    logic [ST_W-1:0] status;
    logic [ST_W-1:0] status_d;
    logic [ST_W-1:0] st_set;
    logic [ST_W-1:0] st_clr;

    logic                 rd_only;
    logic                 ram_we;
    logic                 reg_we;
    logic [ADDR_SIZE-1:0] rd_data;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
`endif

    dmem_decode #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_decode (
        .daddr    (daddr),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .acc      (acc),
        .word_idx (word_idx),
        .reg_sel  (reg_sel)
    );

    assign ram_idx = word_idx[IDX_W-1:0];

    always_comb begin
        rd_only = MemRead && !MemWrite;
        ram_we  = MemWrite && (acc == ACC_RAM);
        reg_we  = MemWrite && (acc == ACC_REG);

        rd_data = '0;
        if (acc == ACC_RAM) begin
            rd_data = ram[ram_idx];
        end else if (acc == ACC_REG) begin
            case (reg_sel)
                REG_GPIO_OUT: rd_data = ADDR_SIZE'(gpio_out);
                REG_GPIO_IN:  rd_data = ADDR_SIZE'(sync2);
`ifdef DMEM_CYCLE_COUNTER_EN
                REG_CYCLE:    rd_data = ADDR_SIZE'(cycle_q);
`endif
                REG_STATUS:   rd_data = ADDR_SIZE'(status);
                default:      rd_data = '0;
            endcase
        end
        // A simultaneous read+write still writes but never returns data.
        ddata_r = rd_only ? rd_data : '0;

        st_set                = '0;
        st_set[ST_MISALIGNED] = (acc == ACC_MISALIGNED);
        st_set[ST_UNMAPPED]   = (acc == ACC_UNMAPPED);
        st_set[ST_COLLISION]  = MemRead && MemWrite;

        st_clr = '0;
        if (reg_we && (reg_sel == REG_STATUS)) begin
            st_clr = ddata_w[ST_W-1:0];
        end
        // Set is ORed in after the clear so a same-cycle event survives.
        status_d = (status & ~st_clr) | st_set;
    end

    // RAM has no reset and keeps committing stores during RESET.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_idx] <= ddata_w;
        end
    end

    // RESET has priority, so register stores in a reset cycle drop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
            status   <= '0;
            err      <= 1'b0;
        end else begin
            sync1  <= gpio_in;
            sync2  <= sync1;
            status <= status_d;
            err    <= |status;
            if (reg_we && (reg_sel == REG_GPIO_OUT)) begin
                gpio_out <= ddata_w[15:0];
            end
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Each task drives one scenario and compares against hand-computed values.
module tb_dmem_responder;

    logic        CLK;
    logic        RESET;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic [31:0] ddata_r;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        err;

    int checks = 0;
    int fails  = 0;

    dmem_responder #(
        .DATA_SIZE (1024),
        .ADDR_SIZE (32)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .daddr    (daddr),
        .ddata_w  (ddata_w),
        .ddata_r  (ddata_r),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        MemRead  = rd;
        MemWrite = wr;
        daddr    = a;
        ddata_w  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        gpio_in = 16'h0;
        idle();
        step();
        step();
        RESET = 1'b0;
        if (gpio_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_gpio_out: got %h want 0000", gpio_out);
        end
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err: got %b want 0", err);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL reset_status: got %h want 0", ddata_r);
        end
        checks++;
        idle();
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL idle_rdata: got %h want 0", ddata_r);
        end
        checks++;
    endtask

    task automatic test_ram();
        drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b1, 32'h14, 32'h0BADF00D);
        step();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        if (ddata_r !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL ram_load_10: got %h want deadbeef", ddata_r);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        if (ddata_r !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL ram_load_14: got %h want 0badf00d", ddata_r);
        end
        checks++;
        idle();
        step();
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL ram_err: got %b want 0", err);
        end
        checks++;
    endtask

    task automatic test_gpio_out();
        drive(1'b0, 1'b1, 32'h1000, 32'h1234A5A5);
        step();
        idle();
        if (gpio_out !== 16'hA5A5) begin
            fails++;
            $display("FAIL gpio_out_pin: got %h want a5a5", gpio_out);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h1000, 32'h0);
        #1;
        if (ddata_r !== 32'h0000A5A5) begin
            fails++;
            $display("FAIL gpio_out_read: got %h want 0000a5a5", ddata_r);
        end
        checks++;
        idle();
    endtask

    task automatic test_ro_write();
        drive(1'b0, 1'b1, 32'h1004, 32'hFFFFFFFF);
        step();
        idle();
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL ro_write_status: got %h want 0", ddata_r);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h1004, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL ro_write_gpio_in: got %h want 0", ddata_r);
        end
        checks++;
        idle();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b0, 32'h6, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL misal_rdata: got %h want 0", ddata_r);
        end
        checks++;
        step();
        idle();
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL misal_err_early: got %b want 0", err);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h1) begin
            fails++;
            $display("FAIL misal_status: got %h want 1", ddata_r);
        end
        checks++;
        idle();
        step();
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL misal_err: got %b want 1", err);
        end
        checks++;
        drive(1'b0, 1'b1, 32'h100C, 32'h1);
        step();
        idle();
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL misal_clear: got %h want 0", ddata_r);
        end
        checks++;
        idle();
        step();
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL misal_err_clear: got %b want 0", err);
        end
        checks++;
        drive(1'b0, 1'b1, 32'h12, 32'h11111111);
        step();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        if (ddata_r !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL misal_no_write: got %h want deadbeef", ddata_r);
        end
        checks++;
        drive(1'b0, 1'b1, 32'h100C, 32'h7);
        step();
        idle();
        step();
    endtask

    task automatic test_unmapped();
        drive(1'b1, 1'b0, 32'h2000, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL unmap_rdata: got %h want 0", ddata_r);
        end
        checks++;
        step();
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h2) begin
            fails++;
            $display("FAIL unmap_status: got %h want 2", ddata_r);
        end
        checks++;
        drive(1'b0, 1'b1, 32'h100C, 32'h7);
        step();
        idle();
        step();
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b1, 32'h20, 32'h55);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL coll_rdata: got %h want 0", ddata_r);
        end
        checks++;
        step();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        if (ddata_r !== 32'h55) begin
            fails++;
            $display("FAIL coll_ram: got %h want 55", ddata_r);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h4) begin
            fails++;
            $display("FAIL coll_status: got %h want 4", ddata_r);
        end
        checks++;
        drive(1'b1, 1'b1, 32'h100C, 32'h4);
        step();
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h4) begin
            fails++;
            $display("FAIL set_wins: got %h want 4", ddata_r);
        end
        checks++;
        drive(1'b0, 1'b1, 32'h100C, 32'h4);
        step();
        drive(1'b1, 1'b0, 32'h100C, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL coll_clear: got %h want 0", ddata_r);
        end
        checks++;
        idle();
        step();
    endtask

    task automatic test_gpio_in();
        #2;
        gpio_in = 16'h00FF;
        drive(1'b1, 1'b0, 32'h1004, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL gpio_in_e0: got %h want 0", ddata_r);
        end
        checks++;
        step();
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL gpio_in_e1: got %h want 0", ddata_r);
        end
        checks++;
        step();
        if (ddata_r !== 32'h000000FF) begin
            fails++;
            $display("FAIL gpio_in_e2: got %h want 000000ff", ddata_r);
        end
        checks++;
        idle();
    endtask

    task automatic test_reset_store();
        RESET = 1'b1;
        drive(1'b0, 1'b1, 32'h30, 32'hCAFE0001);
        step();
        drive(1'b0, 1'b1, 32'h1000, 32'h0000BEEF);
        step();
        RESET = 1'b0;
        idle();
        if (gpio_out !== 16'h0) begin
            fails++;
            $display("FAIL rst_gpio_drop: got %h want 0000", gpio_out);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h30, 32'h0);
        #1;
        if (ddata_r !== 32'hCAFE0001) begin
            fails++;
            $display("FAIL rst_ram_commit: got %h want cafe0001", ddata_r);
        end
        checks++;
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        if (ddata_r !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rst_ram_kept: got %h want deadbeef", ddata_r);
        end
        checks++;
        idle();
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL rst_err: got %b want 0", err);
        end
        checks++;
    endtask

    task automatic test_cycle();
        RESET = 1'b1;
        idle();
        step();
        RESET = 1'b0;
        repeat (100) step();
`ifdef DMEM_CYCLE_COUNTER_EN
        drive(1'b1, 1'b0, 32'h1008, 32'h0);
        #1;
        if (ddata_r !== 32'd100) begin
            fails++;
            $display("FAIL cycle_100: got %0d want 100", ddata_r);
        end
        checks++;
        force dut.cycle_q = 32'hFFFFFFFF;
        #1;
        release dut.cycle_q;
        if (ddata_r !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL cycle_max: got %h want ffffffff", ddata_r);
        end
        checks++;
        step();
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL cycle_wrap: got %h want 0", ddata_r);
        end
        checks++;
        idle();
`else
        drive(1'b1, 1'b0, 32'h1008, 32'h0);
        #1;
        if (ddata_r !== 32'h0) begin
            fails++;
            $display("FAIL cycle_unmap_rdata: got %h want 0", ddata_r);
        end
        checks++;
        step();
        idle();
        step();
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL cycle_unmap_err: got %b want 1", err);
        end
        checks++;
`endif
    endtask

    initial begin
        RESET   = 1'b1;
        gpio_in = 16'h0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        daddr    = 32'h0;
        ddata_w  = 32'h0;
        @(negedge CLK);
        test_reset();
        test_ram();
        test_gpio_out();
        test_ro_write();
        test_misaligned();
        test_unmapped();
        test_collision();
        test_gpio_in();
        test_reset_store();
        test_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
